// File: rtl/spi_master_engine_if.sv
// spi_master_engine_if: bus-side handshake between the CSR block and the SPI engine.
// Optional feature macro: SPI_LSB_FIRST_EN adds the lsb_first request bit.
interface spi_master_engine_if #(
  parameter int DATA_WIDTH = 64,
  parameter int PERI_CNT   = 4,
  parameter int CLK_DIV_W  = 8
);
  localparam int BSEL_W = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1;
  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;

  logic                  start_txn;
  logic [1:0]            spi_mode;
  logic [BSEL_W-1:0]     byte_sel;
  logic [CLK_DIV_W-1:0]  clk_div;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [PERI_CNT-1:0]   chip_sel_one_cold;
`ifdef SPI_LSB_FIRST_EN
  logic                  lsb_first;
`endif
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  end_txn;
  logic                  cfg_err;
  logic [CNT_W-1:0]      bit_count;

  modport master (
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    output start_txn, spi_mode, byte_sel, clk_div, wr_data, chip_sel_one_cold,
    input  rd_data, busy, end_txn, cfg_err, bit_count
  );

  modport slave (
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  start_txn, spi_mode, byte_sel, clk_div, wr_data, chip_sel_one_cold,
    output rd_data, busy, end_txn, cfg_err, bit_count
  );
endinterface

// File: rtl/spi_master_engine.sv
// spi_master_engine: full-duplex SPI controller, all four CPOL/CPHA modes, programmable
// SCLK divider, 1..DATA_WIDTH/8 byte transfers, one-cold chip selects with setup/hold spacing.
// Optional feature macro: SPI_LSB_FIRST_EN (LSB-first bit order selected per transfer).
module spi_master_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int PERI_CNT   = 4,
  parameter int CLK_DIV_W  = 8
) (
  input  logic                clk,
  input  logic                sync_rst,
  input  logic                clk_en,
  spi_master_engine_if.slave  bus,
  input  logic                poci,
  output logic                sclk,
  output logic                copi,
  output logic [PERI_CNT-1:0] s_chip_sel_one_cold
);
  localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
  localparam int HALF_W = CNT_W + 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_DONE} state_t;

  state_t                state_r, state_s;
  logic [CLK_DIV_W-1:0]  div_cnt_r, div_cnt_s, div_r, div_s;
  logic [HALF_W-1:0]     half_cnt_r, half_cnt_s;
  logic                  cpol_r, cpol_s, cpha_r, cpha_s, lsb_r, lsb_s;
  logic [CNT_W-1:0]      nbits_r, nbits_s, bit_cnt_r, bit_cnt_s;
  logic [DATA_WIDTH-1:0] tx_r, tx_s, rx_r, rx_s, rd_r, rd_s;
  logic                  sclk_r, sclk_s, copi_r, copi_s;
  logic [PERI_CNT-1:0]   cs_r, cs_s;
  logic                  busy_r, busy_s, end_r, end_s, err_r, err_s;
  logic                  lsb_in_s, div_end_s, half_last_s, sample_s;
  logic [CNT_W-1:0]      n_req_s;

  // True when exactly one select line is low.
  function automatic logic one_cold_ok(input logic [PERI_CNT-1:0] sel);
    int zeros;
    zeros = 32'sd0;
    for (int i = 32'sd0; i < PERI_CNT; i++) zeros = zeros + (sel[i] ? 32'sd0 : 32'sd1);
    return (zeros == 32'sd1);
  endfunction

  // MSB-first: slice moved to the top so the head bit is always tx[DATA_WIDTH-1].
  // LSB-first: slice kept at the bottom, upper bits cleared, head bit is tx[0].
  function automatic logic [DATA_WIDTH-1:0] tx_align(input logic [DATA_WIDTH-1:0] data,
                                                     input logic [CNT_W-1:0] nbits,
                                                     input logic lsb);
    logic [DATA_WIDTH-1:0] mask;
    mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - int'(nbits));
    return lsb ? (data & mask) : (data << (DATA_WIDTH - int'(nbits)));
  endfunction

  function automatic logic tx_head(input logic [DATA_WIDTH-1:0] tx, input logic lsb);
    return lsb ? tx[0] : tx[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] tx,
                                                     input logic lsb);
    return lsb ? (tx >> 32'd1) : (tx << 32'd1);
  endfunction

  // MSB-first fills from bit 0 upwards; LSB-first fills from the top and is realigned at the end.
  function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] rx,
                                                     input logic b, input logic lsb);
    return lsb ? {b, rx[DATA_WIDTH-1:1]} : {rx[DATA_WIDTH-2:0], b};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rx_align(input logic [DATA_WIDTH-1:0] rx,
                                                     input logic [CNT_W-1:0] nbits,
                                                     input logic lsb);
    return lsb ? (rx >> (DATA_WIDTH - int'(nbits))) : rx;
  endfunction

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in_s = bus.lsb_first;
`else
  assign lsb_in_s = 1'b0;
`endif

  assign n_req_s     = CNT_W'((32'(bus.byte_sel) + 32'd1) * 32'd8);
  assign div_end_s   = (div_cnt_r == div_r);
  assign half_last_s = (half_cnt_r == ({nbits_r, 1'b0} - HALF_W'(1'b1)));
  // Even half-periods end on a leading edge; CPHA picks whether that edge samples or drives.
  assign sample_s    = (~half_cnt_r[0]) ^ cpha_r;

  // Next-state, datapath and output computation for the transfer sequencer.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    half_cnt_s = half_cnt_r;
    div_s      = div_r;
    cpol_s     = cpol_r;
    cpha_s     = cpha_r;
    lsb_s      = lsb_r;
    nbits_s    = nbits_r;
    bit_cnt_s  = bit_cnt_r;
    tx_s       = tx_r;
    rx_s       = rx_r;
    rd_s       = rd_r;
    sclk_s     = sclk_r;
    copi_s     = copi_r;
    cs_s       = cs_r;
    err_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        sclk_s = bus.spi_mode[0];
        if (bus.start_txn && one_cold_ok(bus.chip_sel_one_cold)) begin
          state_s    = ST_SETUP;
          cpol_s     = bus.spi_mode[0];
          cpha_s     = bus.spi_mode[1];
          lsb_s      = lsb_in_s;
          div_s      = bus.clk_div;
          nbits_s    = n_req_s;
          bit_cnt_s  = n_req_s;
          div_cnt_s  = {CLK_DIV_W{1'b0}};
          half_cnt_s = {HALF_W{1'b0}};
          rx_s       = {DATA_WIDTH{1'b0}};
          cs_s       = bus.chip_sel_one_cold;
          tx_s       = tx_align(bus.wr_data, n_req_s, lsb_in_s);
          // CPHA=0 peripherals sample on the first edge, so the first bit goes out with CS.
          if (!bus.spi_mode[1]) begin
            copi_s = tx_head(tx_s, lsb_in_s);
            tx_s   = tx_shift(tx_s, lsb_in_s);
          end else begin
            copi_s = copi_r;
          end
        end else if (bus.start_txn) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
      end
      ST_SETUP: begin
        if (div_end_s) begin
          div_cnt_s = {CLK_DIV_W{1'b0}};
          state_s   = ST_SHIFT;
        end else begin
          div_cnt_s = div_cnt_r + CLK_DIV_W'(1'b1);
        end
      end
      ST_SHIFT: begin
        if (div_end_s) begin
          div_cnt_s = {CLK_DIV_W{1'b0}};
          sclk_s    = ~sclk_r;
          if (sample_s) begin
            rx_s      = rx_shift(rx_r, poci, lsb_r);
            bit_cnt_s = bit_cnt_r - CNT_W'(1'b1);
          end else begin
            copi_s = tx_head(tx_r, lsb_r);
            tx_s   = tx_shift(tx_r, lsb_r);
          end
          if (half_last_s) begin
            state_s    = ST_HOLD;
            half_cnt_s = {HALF_W{1'b0}};
          end else begin
            half_cnt_s = half_cnt_r + HALF_W'(1'b1);
          end
        end else begin
          div_cnt_s = div_cnt_r + CLK_DIV_W'(1'b1);
        end
      end
      ST_HOLD: begin
        if (div_end_s) begin
          div_cnt_s = {CLK_DIV_W{1'b0}};
          state_s   = ST_DONE;
          cs_s      = {PERI_CNT{1'b1}};
          rd_s      = rx_align(rx_r, nbits_r, lsb_r);
        end else begin
          div_cnt_s = div_cnt_r + CLK_DIV_W'(1'b1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cs_s    = {PERI_CNT{1'b1}};
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    end_s  = (state_s == ST_DONE);
  end

  // State and output registers; reset dominates, clk_en low freezes everything.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_r    <= ST_IDLE;
      div_cnt_r  <= {CLK_DIV_W{1'b0}};
      half_cnt_r <= {HALF_W{1'b0}};
      div_r      <= {CLK_DIV_W{1'b0}};
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      lsb_r      <= 1'b0;
      nbits_r    <= {CNT_W{1'b0}};
      bit_cnt_r  <= {CNT_W{1'b0}};
      tx_r       <= {DATA_WIDTH{1'b0}};
      rx_r       <= {DATA_WIDTH{1'b0}};
      rd_r       <= {DATA_WIDTH{1'b0}};
      sclk_r     <= 1'b0;
      copi_r     <= 1'b0;
      cs_r       <= {PERI_CNT{1'b1}};
      busy_r     <= 1'b0;
      end_r      <= 1'b0;
      err_r      <= 1'b0;
    end else if (clk_en) begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      half_cnt_r <= half_cnt_s;
      div_r      <= div_s;
      cpol_r     <= cpol_s;
      cpha_r     <= cpha_s;
      lsb_r      <= lsb_s;
      nbits_r    <= nbits_s;
      bit_cnt_r  <= bit_cnt_s;
      tx_r       <= tx_s;
      rx_r       <= rx_s;
      rd_r       <= rd_s;
      sclk_r     <= sclk_s;
      copi_r     <= copi_s;
      cs_r       <= cs_s;
      busy_r     <= busy_s;
      end_r      <= end_s;
      err_r      <= err_s;
    end
  end

  assign sclk                = sclk_r;
  assign copi                = copi_r;
  assign s_chip_sel_one_cold = cs_r;
  assign bus.rd_data         = rd_r;
  assign bus.busy            = busy_r;
  assign bus.end_txn         = end_r;
  assign bus.cfg_err         = err_r;
  assign bus.bit_count       = bit_cnt_r;
endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: randomized and directed transfers against an edge-level SPI peripheral model.
module tb_spi_master_engine;
  localparam int DW = 64;
  localparam int PC = 4;
  localparam int CDW = 8;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          sync_rst, clk_en, poci, sclk, copi;
  logic [PC-1:0] cs;

  spi_master_engine_if #(.DATA_WIDTH(DW), .PERI_CNT(PC), .CLK_DIV_W(CDW)) bus_if ();

  spi_master_engine #(.DATA_WIDTH(DW), .PERI_CNT(PC), .CLK_DIV_W(CDW)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .bus(bus_if),
    .poci(poci), .sclk(sclk), .copi(copi), .s_chip_sel_one_cold(cs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Peripheral model state
  logic [63:0] per_word = 64'd0;
  logic [63:0] per_rx = 64'd0;
  int          per_n = 8;
  int          per_idx = 0;
  logic        per_cpol = 1'b0, per_cpha = 1'b0;
  logic        poci_m = 1'b0, loopback = 1'b0;
  logic        sclk_prev = 1'b0, copi_prev = 1'b0, cs_prev_on = 1'b0;
  logic        mon_cs_on, mon_edge, mon_lead, mon_drive;
  int          rise_cnt = 0, bad_copi = 0, busy_cnt = 0, end_cnt = 0;

  assign poci = loopback ? copi : poci_m;

  // Peripheral: drives poci on its drive edges, captures copi on sample edges, audits copi timing.
  always @(negedge clk) begin
    mon_cs_on = (cs != 4'hF);
    mon_edge  = mon_cs_on && (sclk != sclk_prev);
    mon_lead  = (sclk != per_cpol);
    mon_drive = mon_edge && (mon_lead == per_cpha);
    if (bus_if.busy) busy_cnt++;
    if (bus_if.end_txn) end_cnt++;
    if (mon_cs_on && !cs_prev_on) begin
      if (!per_cpha) begin
        poci_m  = per_word[per_n-1];
        per_idx = per_n - 2;
      end else begin
        per_idx = per_n - 1;
      end
    end else if (mon_edge) begin
      if (sclk && !sclk_prev) rise_cnt++;
      if (mon_drive) begin
        if (per_idx >= 0) begin
          poci_m  = per_word[per_idx];
          per_idx = per_idx - 1;
        end
      end else begin
        per_rx = {per_rx[62:0], copi};
      end
    end
    if (mon_cs_on && cs_prev_on && (copi != copi_prev) && !mon_drive) bad_copi++;
    sclk_prev  = sclk;
    copi_prev  = copi;
    cs_prev_on = mon_cs_on;
  end

  // One transfer; entered and left #1 after a posedge. Cycle 0 is the start-sampling cycle.
  task automatic run_txn(input logic [1:0] mode, input int bsel, input int div,
                         input logic [63:0] wr, input logic [63:0] pw, input logic [PC-1:0] sel,
                         input logic loop, input logic hold_start, input int frz_at, input int frz_len);
    int n, cyc, lat_exp, frz_bad;
    logic [63:0] mask, exp_rd;
    logic got, fz_sclk, fz_copi;
    logic [PC-1:0] fz_cs;
    n       = 8 * (bsel + 1);
    mask    = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    exp_rd  = (loop ? wr : pw) & mask;
    lat_exp = 1 + (2 * n + 2) * (div + 1) + frz_len;
    per_word = pw; per_n = n; per_cpol = mode[0]; per_cpha = mode[1]; per_rx = 64'd0;
    loopback = loop; rise_cnt = 0; bad_copi = 0; busy_cnt = 0;
    fz_sclk = 1'b0; fz_copi = 1'b0; fz_cs = 4'hF;
    bus_if.spi_mode = mode;
    bus_if.byte_sel = BW'(bsel);
    bus_if.clk_div = CDW'(div);
    bus_if.wr_data = wr;
    bus_if.chip_sel_one_cold = sel;
    bus_if.start_txn = 1'b1;
    @(posedge clk); #1;
    check_eq("bit_count_load", 64'(bus_if.bit_count), 64'(n));
    check_eq("busy_rise", 64'(bus_if.busy), 64'd1);
    check_eq("cs_assert", 64'(cs), 64'(sel));
    bus_if.start_txn = hold_start;
    bus_if.wr_data = {$urandom, $urandom};
    bus_if.clk_div = CDW'($urandom);
    bus_if.byte_sel = BW'($urandom);
    bus_if.chip_sel_one_cold = PC'($urandom);
    cyc = 0; got = 1'b0; frz_bad = 0;
    while (!got && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (frz_len > 0 && cyc == frz_at) begin
        clk_en = 1'b0; fz_sclk = sclk; fz_copi = copi; fz_cs = cs;
      end else if (frz_len > 0 && cyc > frz_at && cyc <= frz_at + frz_len) begin
        if (sclk !== fz_sclk || copi !== fz_copi || cs !== fz_cs) frz_bad++;
        if (cyc == frz_at + frz_len) clk_en = 1'b1;
      end
      got = bus_if.end_txn;
    end
    check_eq("latency", 64'(cyc + 1), 64'(lat_exp));
    check_eq("rd_data", bus_if.rd_data, exp_rd);
    check_eq("copi_stream", per_rx & mask, wr & mask);
    check_eq("sclk_rises", 64'(rise_cnt), 64'(n));
    check_eq("copi_drive_edge_only", 64'(bad_copi), 64'd0);
    if (frz_len > 0) check_eq("freeze_hold", 64'(frz_bad), 64'd0);
    @(posedge clk); #1;
    bus_if.start_txn = 1'b0;
    check_eq("busy_cycles", 64'(busy_cnt), 64'(lat_exp));
    check_eq("busy_fall", 64'(bus_if.busy), 64'd0);
    check_eq("end_pulse", 64'(bus_if.end_txn), 64'd0);
    check_eq("cs_idle", 64'(cs), 64'hF);
    check_eq("sclk_idle", 64'(sclk), 64'(mode[0]));
    check_eq("rd_hold", bus_if.rd_data, exp_rd);
  endtask

  task automatic cfg_reject(input logic [PC-1:0] sel);
    bus_if.spi_mode = 2'b00;
    bus_if.chip_sel_one_cold = sel;
    bus_if.start_txn = 1'b1;
    @(posedge clk); #1;
    bus_if.start_txn = 1'b0;
    check_eq("cfg_err_pulse", 64'(bus_if.cfg_err), 64'd1);
    check_eq("cfg_busy", 64'(bus_if.busy), 64'd0);
    check_eq("cfg_cs", 64'(cs), 64'hF);
    @(posedge clk); #1;
    check_eq("cfg_err_clear", 64'(bus_if.cfg_err), 64'd0);
    check_eq("cfg_busy_after", 64'(bus_if.busy), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_sclk"}, 64'(sclk), 64'd0);
    check_eq({tag, "_copi"}, 64'(copi), 64'd0);
    check_eq({tag, "_cs"}, 64'(cs), 64'hF);
    check_eq({tag, "_rd"}, bus_if.rd_data, 64'd0);
    check_eq({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
    check_eq({tag, "_end"}, 64'(bus_if.end_txn), 64'd0);
    check_eq({tag, "_err"}, 64'(bus_if.cfg_err), 64'd0);
    check_eq({tag, "_bitcnt"}, 64'(bus_if.bit_count), 64'd0);
  endtask

  initial begin
    logic [1:0] m;
    logic [PC-1:0] s;
    logic [PC-1:0] one;
    int snap;
    sync_rst = 1'b1; clk_en = 1'b1;
    bus_if.start_txn = 1'b0; bus_if.spi_mode = 2'b00; bus_if.byte_sel = 3'd0;
    bus_if.clk_div = 8'd0; bus_if.wr_data = 64'd0; bus_if.chip_sel_one_cold = 4'hF;
`ifdef SPI_LSB_FIRST_EN
    bus_if.lsb_first = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    sync_rst = 1'b0;
    @(posedge clk); #1;

    // Mode 0 loopback, single byte, fastest divider
    run_txn(2'b00, 0, 0, 64'hA5, 64'h0, 4'b1110, 1'b1, 1'b0, 0, 0);
    // Mode 3, full width, divider 3
    run_txn(2'b11, 7, 3, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 4'b0111, 1'b0, 1'b0, 0, 0);
    // Modes 1 and 2, two bytes
    run_txn(2'b01, 1, 1, 64'hBEEF, 64'hBEEF, 4'b1101, 1'b0, 1'b1, 0, 0);
    run_txn(2'b10, 1, 2, 64'hBEEF, 64'hBEEF, 4'b1011, 1'b0, 1'b0, 0, 0);

    // Rejected starts
    cfg_reject(4'b1111);
    cfg_reject(4'b0011);

    // Reset in the middle of SHIFT
    per_word = 64'h5A5A; per_n = 16; per_cpol = 1'b0; per_cpha = 1'b0; loopback = 1'b0;
    bus_if.spi_mode = 2'b00; bus_if.byte_sel = 3'd1; bus_if.clk_div = 8'd1;
    bus_if.wr_data = 64'h1234; bus_if.chip_sel_one_cold = 4'b1101; bus_if.start_txn = 1'b1;
    @(posedge clk); #1;
    bus_if.start_txn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_pre_busy", 64'(bus_if.busy), 64'd1);
    snap = end_cnt;
    sync_rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    sync_rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("abort_no_end", 64'(end_cnt), 64'(snap));
    run_txn(2'b00, 1, 1, 64'hC3D2, 64'h6E91, 4'b1110, 1'b0, 1'b0, 0, 0);

    // clk_en held low for 10 cycles mid-transfer
    run_txn(2'b00, 1, 1, 64'h9A3C, 64'h47E1, 4'b1011, 1'b0, 1'b0, 20, 10);

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      m = 2'($urandom_range(0, 3));
      one = 4'b0001;
      s = ~(one << $urandom_range(0, 3));
      run_txn(m, $urandom_range(0, 7), $urandom_range(0, 3), {$urandom, $urandom},
              {$urandom, $urandom}, s, 1'b0, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
